pkt_tx: RTL and testbench

PKT_TX -- requirements
Module: pkt_tx

---
 rtl/pkt_tx_pkg.sv | 21 ++
 rtl/pkt_tx_ram.sv | 29 ++
 rtl/pkt_tx.sv | 158 +++++++++++++++
 tb/tb_pkt_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared types and constants for the packet transmitter.
//   state_e    : controller states (IDLE, LOAD, SEND)
//   LFSR_SEED  : reset value of the gap-insertion LFSR
//   LFSR_TAPS  : Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1)
//   lfsr_step  : one Galois right-shift step of the LFSR
package pkt_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pkt_tx_ram.sv
// Single-port packet buffer, DEPTH x DWIDTH, registered read (1-cycle latency).
//   clk_i : clock
//   we    : write enable (write wdata at addr)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : read data, mem[addr] sampled on the previous rising edge
module pkt_tx_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage is never reset; contents survive a mid-packet reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pkt_tx.sv
// Packet transmitter: buffers one packet from a load interface and replays it
// on an Avalon-ST source (readyLatency 0) with sop/eop delimiters.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   ld_data_i/valid/last  : load word, its valid, final-word marker
//   ld_ready_o            : load word accepted when ld_valid_i && ld_ready_o
//   src_data_o/valid      : source word and valid
//   src_startofpacket_o   : first word of packet
//   src_endofpacket_o     : last word of packet
//   src_ready_i           : sink ready
//   ovf_o                 : one-cycle pulse when a packet is cut at MAX_PKT_LEN
// Optional macro PKT_TX_GAP_EN: LFSR-driven idle cycles between source words.
module pkt_tx
    import pkt_tx_pkg::*;
#(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] ld_data_i,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              ovf_o
);

    localparam int unsigned CW = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

    state_e        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [CW-1:0] rd_idx_q, rd_idx_n;
    logic [CW-1:0] rd_next_c;
    logic          ld_ready_n, valid_n, sop_n, eop_n, ovf_n;
    logic          acc_c, hs_c, gap_c;
    logic          ram_we_c;
    logic [AW-1:0] ram_addr_c;

`ifdef PKT_TX_GAP_EN
    logic [15:0] lfsr_q, lfsr_n;

    // Free-running gap generator; bit 0 of the next value gates new words.
    assign lfsr_n = lfsr_step(lfsr_q);
    assign gap_c  = lfsr_n[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_n;
        end
    end
`else
    assign gap_c = 1'b0;
`endif

    // Buffer: written at cnt during load, read at the look-ahead index during send.
    pkt_tx_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AWIDTH (AW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (ld_data_i),
        .rdata (src_data_o)
    );

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            rd_idx_q            <= '0;
            ld_ready_o          <= 1'b0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            ovf_o               <= 1'b0;
        end else begin
            state_q             <= state_n;
            cnt_q               <= cnt_n;
            rd_idx_q            <= rd_idx_n;
            ld_ready_o          <= ld_ready_n;
            src_valid_o         <= valid_n;
            src_startofpacket_o <= sop_n;
            src_endofpacket_o   <= eop_n;
            ovf_o               <= ovf_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        rd_idx_n   = rd_idx_q;
        valid_n    = src_valid_o;
        sop_n      = src_startofpacket_o;
        eop_n      = src_endofpacket_o;
        ovf_n      = 1'b0;
        ram_we_c   = 1'b0;
        ram_addr_c = AW'(cnt_q);
        acc_c      = ld_valid_i && ld_ready_o;
        hs_c       = src_valid_o && src_ready_i;
        // Index of the word presented next cycle; fetching it now keeps the
        // RAM output aligned with the source register without bubbles.
        rd_next_c  = hs_c ? rd_idx_q + CW'(1) : rd_idx_q;

        case (state_q)
            IDLE, LOAD: begin
                rd_idx_n = '0;
                valid_n  = 1'b0;
                sop_n    = 1'b0;
                eop_n    = 1'b0;
                if (acc_c) begin
                    ram_we_c = 1'b1;
                    cnt_n    = cnt_q + CW'(1);
                    if (ld_last_i || (cnt_q == CW'(MAX_PKT_LEN - 1))) begin
                        state_n = SEND;
                        ovf_n   = !ld_last_i;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            SEND: begin
                ram_addr_c = AW'(rd_next_c);
                rd_idx_n   = rd_next_c;
                if (hs_c && src_endofpacket_o) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    rd_idx_n = '0;
                    valid_n  = 1'b0;
                    sop_n    = 1'b0;
                    eop_n    = 1'b0;
                end else if (!(src_valid_o && !src_ready_i)) begin
                    // Only a free output slot may take a new word; a stalled
                    // word keeps its valid and delimiters.
                    valid_n = (rd_next_c < cnt_q) && !gap_c;
                    sop_n   = valid_n && (rd_next_c == '0);
                    eop_n   = valid_n && (rd_next_c == cnt_q - CW'(1));
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ld_ready_n = (state_n != SEND);
    end

endmodule

// File: tb/tb_pkt_tx.sv
module tb_pkt_tx;

    localparam int unsigned DW   = 8;
    localparam int unsigned MAXL = 16;

    typedef logic [7:0] bq_t[$];

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] ld_data_i = '0;
    logic          ld_valid_i = 1'b0;
    logic          ld_last_i = 1'b0;
    logic          ld_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;
    logic          src_ready_i = 1'b0;
    logic          ovf_o;

    int n_checks = 0;
    int n_fail   = 0;
`ifdef PKT_TX_GAP_EN
    int max_lat  = 200;
`else
    int max_lat  = 2;
`endif

    always #5 clk_i = ~clk_i;

    pkt_tx #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN (MAXL)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ld_data_i           (ld_data_i),
        .ld_valid_i          (ld_valid_i),
        .ld_last_i           (ld_last_i),
        .ld_ready_o          (ld_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .ovf_o               (ovf_o)
    );

    // Load words back to back; final word carries ld_last_i when last_en.
    task automatic load_pkt(input bq_t w, input bit last_en);
        for (int i = 0; i < w.size(); i++) begin
            int wait_c = 0;
            while (ld_ready_o !== 1'b1 && wait_c < 50) begin
                @(negedge clk_i);
                wait_c++;
            end
            n_checks++;
            if (ld_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready word %0d: ld_ready_o=%b, required 1", i, ld_ready_o);
            end
            n_checks++;
            if (src_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load_src_valid word %0d: src_valid_o=%b, required 0", i, src_valid_o);
            end
            ld_valid_i = 1'b1;
            ld_data_i  = w[i];
            ld_last_i  = last_en && (i == w.size() - 1);
            @(negedge clk_i);
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    // Drain one packet and check data order, delimiters, stall stability, latency.
    task automatic collect(input string name, input bq_t exp, input int stall_at,
                           input int stall_len, input bit rand_rdy);
        int k = 0;
        int cyc = 0;
        int lat = 0;
        int stalled = 0;
        int bubbles = 0;
        bit started = 1'b0;
        bit holding = 1'b0;
        logic [7:0] h_data;
        logic h_sop, h_eop, e_sop, e_eop;
        h_data = '0;
        h_sop  = 1'b0;
        h_eop  = 1'b0;
        while (k < exp.size() && cyc < 400) begin
            if (holding) begin
                n_checks++;
                if (src_valid_o !== 1'b1 || src_data_o !== h_data ||
                    src_startofpacket_o !== h_sop || src_endofpacket_o !== h_eop) begin
                    n_fail++;
                    $display("FAIL %s_hold word %0d: valid=%b data=%h sop=%b eop=%b, required 1 %h %b %b",
                             name, k, src_valid_o, src_data_o, src_startofpacket_o,
                             src_endofpacket_o, h_data, h_sop, h_eop);
                end
            end
            if (src_valid_o === 1'b1) started = 1'b1;
            else if (started) bubbles++;
            else lat++;

            if (src_valid_o === 1'b1 && k == stall_at && stalled < stall_len) begin
                src_ready_i = 1'b0;
                stalled++;
            end else if (rand_rdy) begin
                src_ready_i = 1'($urandom_range(0, 1));
            end else begin
                src_ready_i = 1'b1;
            end

            if (src_valid_o === 1'b1 && src_ready_i) begin
                e_sop = (k == 0);
                e_eop = (k == exp.size() - 1);
                n_checks++;
                if (src_data_o !== exp[k] || src_startofpacket_o !== e_sop ||
                    src_endofpacket_o !== e_eop) begin
                    n_fail++;
                    $display("FAIL %s_word %0d: data=%h sop=%b eop=%b, required %h %b %b",
                             name, k, src_data_o, src_startofpacket_o, src_endofpacket_o,
                             exp[k], e_sop, e_eop);
                end
                k++;
                holding = 1'b0;
            end else if (src_valid_o === 1'b1) begin
                holding = 1'b1;
                h_data  = src_data_o;
                h_sop   = src_startofpacket_o;
                h_eop   = src_endofpacket_o;
            end else begin
                holding = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        src_ready_i = 1'b0;
        n_checks++;
        if (k != exp.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words, required %0d", name, k, exp.size());
        end
        n_checks++;
        if (lat > max_lat) begin
            n_fail++;
            $display("FAIL %s_latency: %0d cycles to first valid, required <= %0d", name, lat, max_lat);
        end
`ifndef PKT_TX_GAP_EN
        n_checks++;
        if (bubbles != 0) begin
            n_fail++;
            $display("FAIL %s_bubbles: %0d idle cycles inside packet, required 0", name, bubbles);
        end
`endif
        n_checks++;
        if (src_valid_o !== 1'b0 || ld_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after_eop: valid=%b ld_ready=%b, required 0 1", name, src_valid_o, ld_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, ovf_o, ld_ready_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/sop/eop/ovf/ld_ready=%b, required 00000",
                     {src_valid_o, src_startofpacket_o, src_endofpacket_o, ovf_o, ld_ready_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (ld_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ld_ready_o=%b, required 1", ld_ready_o);
        end
    endtask

    task automatic test_basic();
        bq_t w;
        w = {8'd5, 8'd3, 8'd9, 8'd1};
        load_pkt(w, 1'b1);
        collect("basic", w, -1, 0, 1'b0);
    endtask

    task automatic test_single();
        bq_t w;
        w = {8'h7F};
        load_pkt(w, 1'b1);
        collect("single", w, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        bq_t w;
        w = {8'd1, 8'd2, 8'd3, 8'd4};
        load_pkt(w, 1'b1);
        collect("stall", w, 1, 3, 1'b0);
    endtask

    task automatic test_overflow();
        bq_t w;
        bq_t nxt;
        for (int i = 0; i < 16; i++) w.push_back(8'(8'h20 + i));
        nxt = {8'hEE};
        load_pkt(w, 1'b0);
        n_checks++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pulse: ovf_o=%b, required 1", ovf_o);
        end
        // 17th word waits on the load port while the truncated packet drains.
        ld_valid_i = 1'b1;
        ld_data_i  = 8'hEE;
        ld_last_i  = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_one_cycle: ovf_o=%b, required 0", ovf_o);
        end
        collect("ovf_pkt", w, -1, 0, 1'b0);
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        collect("ovf_next", nxt, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        bq_t w;
        bq_t w2;
        int k = 0;
        int cyc = 0;
        w  = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        w2 = {8'hB1, 8'hB2};
        load_pkt(w, 1'b1);
        src_ready_i = 1'b1;
        while (k < 2 && cyc < 20) begin
            if (src_valid_o === 1'b1) begin
                n_checks++;
                if (src_data_o !== w[k] || src_endofpacket_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_word %0d: data=%h eop=%b, required %h 0",
                             k, src_data_o, src_endofpacket_o, w[k]);
                end
                k++;
            end
            @(negedge clk_i);
            cyc++;
        end
        src_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, ld_ready_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: valid/sop/eop/ld_ready=%b, required 0000",
                     {src_valid_o, src_startofpacket_o, src_endofpacket_o, ld_ready_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (ld_ready_o !== 1'b1 || src_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: ld_ready=%b valid=%b, required 1 0", ld_ready_o, src_valid_o);
        end
        load_pkt(w2, 1'b1);
        collect("rstmid_next", w2, -1, 0, 1'b0);
    endtask

`ifdef PKT_TX_GAP_EN
    task automatic test_gap();
        bq_t w;
        for (int i = 0; i < 10; i++) w.push_back(8'(8'h40 + 3 * i));
        load_pkt(w, 1'b1);
        collect("gap", w, -1, 0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_overflow();
        test_reset_mid_send();
`ifdef PKT_TX_GAP_EN
        test_gap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
